// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver: ps2_clk synchronizer, 11-bit frame capture, 8-entry scan-code FIFO.
// Optional odd-parity validation is enabled with `define PS2_PARITY_CHECK_EN.
module ps2_keyboard (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow
);

  logic [2:0] sync_q, sync_d;
  logic [9:0] buf_q, buf_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] fifo_q [8];
  logic [7:0] fifo_d [8];
  logic [2:0] wptr_q, wptr_d;
  logic [2:0] rptr_q, rptr_d;
  logic [3:0] count_q, count_d;
  logic       ovf_q, ovf_d;
  logic       nd_q, nd_d;

  logic fall, frame_done, frame_ok, full, pop, wr;

  always_comb begin
    sync_d = {sync_q[1:0], ps2_clk};
    nd_d   = nextdata_n;
    fall   = sync_q[2] & ~sync_q[1];

    frame_done = fall && (cnt_q == 4'd10);
    // The stop bit is never stored; it is checked directly as it is sampled.
`ifdef PS2_PARITY_CHECK_EN
    frame_ok = frame_done && !buf_q[0] && ps2_data && (^buf_q[9:1]);
`else
    frame_ok = frame_done && !buf_q[0] && ps2_data;
`endif

    buf_d = buf_q;
    cnt_d = cnt_q;
    if (fall) begin
      if (cnt_q == 4'd10) begin
        cnt_d = 4'd0;
      end else begin
        buf_d[cnt_q] = ps2_data;
        cnt_d        = cnt_q + 4'd1;
      end
    end
  end

  always_comb begin
    full  = (count_q == 4'd8);
    ready = (count_q != 4'd0);
    data  = fifo_q[rptr_q];
    pop   = nd_q && !nextdata_n && ready;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept the byte.
    wr    = frame_ok && (!full || pop);

    fifo_d = fifo_q;
    if (wr) fifo_d[wptr_q] = buf_q[8:1];

    wptr_d  = wr  ? wptr_q + 3'd1 : wptr_q;
    rptr_d  = pop ? rptr_q + 3'd1 : rptr_q;
    count_d = count_q + {3'b000, wr} - {3'b000, pop};
    ovf_d   = ovf_q || (frame_ok && full && !pop);
  end

  assign overflow = ovf_q;

  always_ff @(posedge clk) begin
    if (!clrn) begin
      sync_q  <= 3'b111;
      buf_q   <= '0;
      cnt_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      nd_q    <= 1'b1;
      for (int i = 0; i < 8; i++) fifo_q[i] <= 8'h00;
    end else begin
      sync_q  <= sync_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      nd_q    <= nd_d;
      for (int i = 0; i < 8; i++) fifo_q[i] <= fifo_d[i];
    end
  end

endmodule

// File: tb/tb_ps2_keyboard.sv
// Self-checking bench for ps2_keyboard: expected scan codes queued as frames are sent, checked on pop.
module tb_ps2_keyboard;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       nextdata_n = 1'b1;
  logic [7:0] data;
  logic       ready;
  logic       overflow;

  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] sb [$];
  logic       exp_ovf = 1'b0;

  ps2_keyboard dut (
    .clk        (clk),
    .clrn       (clrn),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .nextdata_n (nextdata_n),
    .data       (data),
    .ready      (ready),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 clrn = 1'b0;
    repeat (3) @(posedge clk);
    #1 clrn = 1'b1;
    sb.delete();
    exp_ovf = 1'b0;
  endtask

  // Sends the first nbits of a frame; only complete valid frames are expected to land.
  task automatic send_frame(input logic [7:0] b, input bit bad_stop, input bit bad_par,
                            input int nbits);
    logic [10:0] f;
    bit          valid;
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
`ifdef PS2_PARITY_CHECK_EN
    valid = !bad_stop && !bad_par;
`else
    valid = !bad_stop;
`endif
    if (nbits == 11 && valid) begin
      if (sb.size() == 8) exp_ovf = 1'b1;
      else sb.push_back(b);
    end
    for (int i = 0; i < nbits; i++) begin
      @(posedge clk); #1 ps2_data = f[i];
      repeat (5) @(posedge clk);
      #1 ps2_clk = 1'b0;
      repeat (5) @(posedge clk);
      #1 ps2_clk = 1'b1;
    end
    #1 ps2_data = 1'b1;
    repeat (8) @(posedge clk);
  endtask

  task automatic read_byte(input string tag, input int len);
    logic [7:0] exp;
    @(negedge clk);
    if (sb.size() == 0) begin
      check({tag, "_rdy_empty"}, ready, 1'b0);
    end else begin
      exp = sb.pop_front();
      check({tag, "_rdy"}, ready, 1'b1);
      check({tag, "_data"}, data, exp);
    end
    @(posedge clk); #1 nextdata_n = 1'b0;
    repeat (len) @(posedge clk);
    #1 nextdata_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check({tag, "_rdy_after"}, ready, sb.size() != 0);
    if (sb.size() != 0) check({tag, "_next"}, data, sb[0]);
  endtask

  initial begin
    do_reset();
    @(negedge clk);
    check("rst_ready", ready, 1'b0);
    check("rst_data", data, 8'h00);
    check("rst_ovf", overflow, 1'b0);

    send_frame(8'h1C, 0, 0, 11);
    read_byte("single_1c", 2);

    send_frame(8'hF0, 0, 0, 11);
    read_byte("seq_f0", 1);
    send_frame(8'h1C, 0, 0, 11);
    read_byte("seq_1c", 3);
    check("seq_ovf", overflow, 1'b0);

    send_frame(8'h1B, 0, 0, 11);
    send_frame(8'h1B, 0, 0, 11);
    send_frame(8'h1B, 0, 0, 11);
    send_frame(8'hF0, 0, 0, 11);
    send_frame(8'h1B, 0, 0, 11);
    read_byte("burst1", 1);
    read_byte("burst2", 2);
    read_byte("burst3", 4);
    read_byte("burst4", 7);
    read_byte("burst5", 3);

    read_byte("empty_pop", 2);
    send_frame(8'h5A, 0, 0, 11);
    read_byte("after_empty", 2);

    send_frame(8'h1C, 1, 0, 11);
    @(negedge clk);
    check("bad_stop_rdy", ready, 1'b0);
    send_frame(8'h1C, 0, 0, 11);
    read_byte("post_bad_stop", 2);

    send_frame(8'h1C, 0, 1, 11);
    read_byte("bad_par", 2);
    check("bad_par_ovf", overflow, 1'b0);

    send_frame(8'h77, 0, 0, 5);
    do_reset();
    send_frame(8'h1C, 0, 0, 11);
    read_byte("mid_rst", 2);

    do_reset();
    for (int i = 0; i < 9; i++) send_frame(8'($urandom_range(0, 255)), 0, 0, 11);
    @(negedge clk);
    check("ovf_set", overflow, exp_ovf);
    check("ovf_exp", exp_ovf, 1'b1);
    for (int i = 0; i < 8; i++) begin
      read_byte("ovf_pop", 2);
      check("ovf_sticky", overflow, 1'b1);
    end
    do_reset();
    @(negedge clk);
    check("ovf_cleared", overflow, 1'b0);
    check("ovf_cleared_rdy", ready, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
